// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I sequencer: fetch/decode/exec/mem/writeback control,
// memory handshakes with ack timeouts, sticky trap and retired-instruction count.
module mc_ctrl_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned INSTRET_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [31:0]          instr,
  input  logic                 zero,
  input  logic                 imem_ack,
  input  logic                 dmem_ack,
  output logic                 imem_req,
  output logic                 ir_we,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 alu_src,
  output logic [3:0]           alu_op,
  output logic                 jalr,
  output logic                 lui,
  output logic                 auipc,
  output logic                 pc_we,
  output logic                 pc_sel,
  output logic                 busy,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [INSTRET_W-1:0] instret
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(LIMIT);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;
  logic                   trap_q, trap_d;
  logic [1:0]             cause_q, cause_d;
  logic                   retire;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7_b5;
  logic       is_lui, is_auipc, is_jal, is_jalr, is_branch;
  logic       is_load, is_store, is_opimm, is_op, is_fence;
  logic       legal, writes_rd, br_taken, timeout_hit, in_ctrl;
  logic [3:0] alu_dec;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign f7_b5        = instr[30];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_opimm  = (opcode == OPC_OPIMM);
  assign is_op     = (opcode == OPC_OP);
  assign is_fence  = (opcode == OPC_FENCE);

  // SYSTEM (ECALL/EBREAK) is deliberately absent, so it decodes as illegal
  assign legal = is_lui | is_auipc | is_jal | is_jalr | is_branch |
                 is_load | is_store | is_opimm | is_op | is_fence;
  assign writes_rd = is_lui | is_auipc | is_jal | is_jalr | is_load | is_opimm | is_op;
  assign timeout_hit = TMO_EN && (cnt_q == CNT_LIMIT);
  assign in_ctrl = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);

  always_comb begin
    alu_dec = ALU_ADD;
    if (is_op || is_opimm) begin
      case (funct3)
        3'b000:  alu_dec = (is_op && f7_b5) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_dec = ALU_SLL;
        3'b010:  alu_dec = ALU_SLT;
        3'b011:  alu_dec = ALU_SLTU;
        3'b100:  alu_dec = ALU_XOR;
        3'b101:  alu_dec = f7_b5 ? ALU_SRA : ALU_SRL;
        3'b110:  alu_dec = ALU_OR;
        default: alu_dec = ALU_AND;
      endcase
    end else if (is_branch) begin
      case (funct3[2:1])
        2'b00:   alu_dec = ALU_SUB;
        2'b10:   alu_dec = ALU_SLT;
        2'b11:   alu_dec = ALU_SLTU;
        default: alu_dec = ALU_ADD;
      endcase
    end
  end

  always_comb begin
    case (funct3)
      3'b000, 3'b101, 3'b111: br_taken = zero;
      3'b001, 3'b100, 3'b110: br_taken = !zero;
      default:                br_taken = 1'b0;
    endcase
  end

  // The wait counter only advances while stalled in FETCH/MEM and is zero
  // everywhere else, which is what makes every entry to those states start at 0.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    instret_d = instret_q;
    trap_d    = trap_q;
    cause_d   = cause_q;
    retire    = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'b10;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        if (!legal) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'b01;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = (is_load || is_store) ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ack) begin
          if (is_store) retire = 1'b1;
          else          state_d = S_WB;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'b11;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB:    retire = 1'b1;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
    if (retire) begin
      instret_d = instret_q + INSTRET_W'(1);
      state_d   = run ? S_FETCH : S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      instret_q <= '0;
      trap_q    <= 1'b0;
      cause_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      instret_q <= instret_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
    end
  end

  always_comb begin
    imem_req   = (state_q == S_FETCH);
    ir_we      = (state_q == S_FETCH) && imem_ack;
    dmem_req   = (state_q == S_MEM);
    dmem_we    = (state_q == S_MEM) && is_store;
    reg_write  = (state_q == S_WB) && writes_rd;
    mem_to_reg = (state_q == S_WB) && is_load;
    alu_src    = in_ctrl && (is_opimm || is_load || is_store || is_jalr || is_auipc);
    alu_op     = in_ctrl ? alu_dec : ALU_ADD;
    jalr       = in_ctrl && is_jalr;
    lui        = in_ctrl && is_lui;
    auipc      = in_ctrl && is_auipc;
    pc_we      = retire;
    pc_sel     = (in_ctrl && (is_jal || is_jalr)) ||
                 ((state_q == S_WB) && is_branch && br_taken);
    busy       = (state_q != S_IDLE) && (state_q != S_TRAP);
    trap       = trap_q;
    trap_cause = cause_q;
    instret    = instret_q;
  end

endmodule
